// File: rtl/sseg_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package sseg_scan_ctrl_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    // Captured display request: hex value, per-digit dp, leading-zero enable.
    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic        lz;
    } disp_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [6:0] SEG7_OFF  = 7'h7F;
    localparam int         DP_BIT    = 7;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    // A digit is a leading zero when it and every digit to its left are zero.
    function automatic logic lz_suppress(input disp_t d, input logic [1:0] idx);
        logic r;
        case (idx)
            2'd1:    r = d.lz && (d.value[15:4] == 12'h000);
            2'd2:    r = d.lz && (d.value[15:8] == 8'h00);
            2'd3:    r = d.lz && (d.value[15:12] == 4'h0);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sseg_hex_decode.sv
// Combinational hex nibble to active-low {g,f,e,d,c,b,a} segment decoder.
module sseg_hex_decode
    import sseg_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Lookup of the glyph for each hex digit.
    always_comb begin
        case (nibble_i)
            4'h0:    seg_o = SEG_0;
            4'h1:    seg_o = SEG_1;
            4'h2:    seg_o = SEG_2;
            4'h3:    seg_o = SEG_3;
            4'h4:    seg_o = SEG_4;
            4'h5:    seg_o = SEG_5;
            4'h6:    seg_o = SEG_6;
            4'h7:    seg_o = SEG_7;
            4'h8:    seg_o = SEG_8;
            4'h9:    seg_o = SEG_9;
            4'hA:    seg_o = SEG_A;
            4'hB:    seg_o = SEG_B;
            4'hC:    seg_o = SEG_C;
            4'hD:    seg_o = SEG_D;
            4'hE:    seg_o = SEG_E;
            4'hF:    seg_o = SEG_F;
            default: seg_o = SEG7_OFF;
        endcase
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with frame-synchronous updates,
// inter-digit blanking and leading-zero suppression.
module sseg_scan_ctrl
    import sseg_scan_ctrl_pkg::*;
#(
    parameter int DWELL_CYCLES = 5,
    parameter int BLANK_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [3:0]  dp,
    input  logic        lz_blank,
    output logic [3:0]  an,
    output logic [7:0]  sseg,
    output logic        frame_done
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    generate
        if (DWELL_CYCLES < 1) begin : g_bad_dwell
            $error("sseg_scan_ctrl: DWELL_CYCLES must be >= 1");
        end
        if (BLANK_CYCLES < 1) begin : g_bad_blank
            $error("sseg_scan_ctrl: BLANK_CYCLES must be >= 1");
        end
    endgenerate

    disp_t         in_s;
    disp_t         pend_q, pend_d;
    disp_t         shad_q, shad_d;
    state_e        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          en_q;
    logic          boundary_s;
    logic [3:0]    an_q, an_d;
    logic [7:0]    sseg_q, sseg_d;
    logic          fd_q, fd_d;
    logic [3:0]    nibble_s;
    logic [6:0]    seg7_s;
    logic          dp_on_s;
    logic          supp_s;

    assign in_s = '{value: value, dp: dp, lz: lz_blank};

    // Scan sequencing, pending capture and frame-boundary shadow update.
    always_comb begin
        pend_d     = load ? in_s : pend_q;
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        boundary_s = 1'b0;
        if (!en) begin
            state_d = ST_BLANK;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_DRIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d    = ST_BLANK;
                        idx_d      = idx_q + 2'd1;
                        cnt_d      = '0;
                        boundary_s = (idx_q == 2'd3);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_BLANK;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end
            endcase
        end
        // A load coinciding with the update edge bypasses pending.
        if (boundary_s || (en && !en_q)) begin
            shad_d = load ? in_s : pend_q;
        end else begin
            shad_d = shad_q;
        end
    end

    assign nibble_s = shad_d.value[{idx_d, 2'b00} +: 4];
    assign dp_on_s  = shad_d.dp[idx_d];
    assign supp_s   = lz_suppress(shad_d, idx_d);

    sseg_hex_decode u_dec (
        .nibble_i (nibble_s),
        .seg_o    (seg7_s)
    );

    // Output pattern derived from the next state so pins line up with the FSM.
    always_comb begin
        an_d   = 4'hF;
        sseg_d = SEG_BLANK;
        fd_d   = 1'b0;
        if (state_d == ST_DRIVE) begin
            if (supp_s) begin
                an_d   = dp_on_s ? ~(4'b0001 << idx_d) : 4'hF;
                sseg_d = {~dp_on_s, SEG7_OFF};
            end else begin
                an_d   = ~(4'b0001 << idx_d);
                sseg_d = {~dp_on_s, seg7_s};
            end
            fd_d = (idx_d == 2'd3) && (cnt_d == DWELL_LAST);
        end else begin
            an_d   = 4'hF;
            sseg_d = SEG_BLANK;
            fd_d   = 1'b0;
        end
    end

    // State, data and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= '0;
            shad_q  <= '0;
            state_q <= ST_BLANK;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            an_q    <= 4'hF;
            sseg_q  <= SEG_BLANK;
            fd_q    <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            shad_q  <= shad_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            en_q    <= en;
            an_q    <= an_d;
            sseg_q  <= sseg_d;
            fd_q    <= fd_d;
        end
    end

    assign an         = an_q;
    assign sseg       = sseg_q;
    assign frame_done = fd_q;

    wire unused_dp_bit = (DP_BIT == 7);

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl with default timing (B=1, D=5).
module tb_sseg_scan_ctrl;

    localparam int D = 5;
    localparam int B = 1;
    localparam int SLOT = B + D;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dp;
    logic        lz_blank;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic        frame_done;

    int tests = 0;
    int fails = 0;

    sseg_scan_ctrl #(
        .DWELL_CYCLES (D),
        .BLANK_CYCLES (B)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .value      (value),
        .load       (load),
        .dp         (dp),
        .lz_blank   (lz_blank),
        .an         (an),
        .sseg       (sseg),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [12:0] exp);
        logic [12:0] obs;
        obs = {an, sseg, frame_done};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed an/sseg/fd=%h/%h/%b expected %h/%h/%b",
                   tag, obs[12:9], obs[8:1], obs[0], exp[12:9], exp[8:1], exp[0]);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Checks n cycles of a frame starting at digit 0's first drive cycle.
    // ld = {lz, dp, value} applied as a one-cycle load at cycle index ld_t1/ld_t2.
    task automatic run_frame(input string tag, input logic [15:0] an_exp,
                             input logic [31:0] sg_exp, input int n,
                             input int ld_t1, input logic [20:0] ld1,
                             input int ld_t2, input logic [20:0] ld2);
        for (int t = 0; t < n; t++) begin
            int d;
            int c;
            d = t / SLOT;
            c = t % SLOT;
            if (c < D)
                check($sformatf("%s_d%0d_c%0d", tag, d, c),
                      {an_exp[d*4 +: 4], sg_exp[d*8 +: 8], (d == 3 && c == D - 1)});
            else
                check($sformatf("%s_gap%0d", tag, d), {4'hF, 8'hFF, 1'b0});
            if (t == ld_t1) begin
                load = 1'b1;
                {lz_blank, dp, value} = ld1;
            end else if (t == ld_t2) begin
                load = 1'b1;
                {lz_blank, dp, value} = ld2;
            end else begin
                load = 1'b0;
            end
            step();
        end
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0;
        value = 16'h0000; dp = 4'h0; lz_blank = 1'b0;
        repeat (3) step();
        check("reset", {4'hF, 8'hFF, 1'b0});

        rst = 1'b0;
        load = 1'b1; value = 16'h12A0; dp = 4'b0000; lz_blank = 1'b0;
        step();
        load = 1'b0;
        check("en_low_dark", {4'hF, 8'hFF, 1'b0});

        en = 1'b1;
        step();
        run_frame("full_scan", 16'h7BDE, 32'hF9A488C0, 24,
                  10, {1'b1, 4'b0100, 16'h0005}, -1, 21'h0);
        run_frame("lz_0005", 16'hFBFE, 32'hFF7FFF92, 24,
                  22, {1'b1, 4'b0000, 16'h0000}, -1, 21'h0);
        run_frame("zero_val", 16'hFFFE, 32'hFFFFFFC0, 24,
                  3, {1'b0, 4'b0000, 16'h1111}, 14, {1'b0, 4'b0000, 16'h2222});
        run_frame("sync_load", 16'h7BDE, 32'hA4A4A4A4, 24, -1, 21'h0, -1, 21'h0);

        run_frame("pre_en_drop", 16'h7BDE, 32'hA4A4A4A4, 8, -1, 21'h0, -1, 21'h0);
        en = 1'b0;
        step();
        check("en_drop_dark", {4'hF, 8'hFF, 1'b0});
        load = 1'b1; value = 16'hBEEF; dp = 4'b0001; lz_blank = 1'b0;
        step();
        load = 1'b0;
        check("en_low_load_dark", {4'hF, 8'hFF, 1'b0});
        en = 1'b1;
        step();
        run_frame("en_restart", 16'h7BDE, 32'h8386860E, 21, -1, 21'h0, -1, 21'h0);

        rst = 1'b1;
        step();
        check("rst_mid_1", {4'hF, 8'hFF, 1'b0});
        step();
        check("rst_mid_2", {4'hF, 8'hFF, 1'b0});
        step();
        check("rst_mid_3", {4'hF, 8'hFF, 1'b0});
        rst = 1'b0;
        step();
        run_frame("post_rst", 16'h7BDE, 32'hC0C0C0C0, 24, -1, 21'h0, -1, 21'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
